// File: rtl/ks_adder_32b.sv
// 32-bit unsigned Kogge-Stone adder, 33-bit registered sum (bit 32 = carry-out).
// Latency 1 cycle, new operands every cycle, no backpressure.

module ks_black_cell (
   input  logic g_hi_i,
   input  logic p_hi_i,
   input  logic g_lo_i,
   input  logic p_lo_i,
   output logic g_o,
   output logic p_o
);
   assign g_o = g_hi_i | (p_hi_i & g_lo_i);
   assign p_o = p_hi_i & p_lo_i;
endmodule

module ks_grey_cell (
   input  logic g_hi_i,
   input  logic p_hi_i,
   input  logic g_lo_i,
   output logic g_o
);
   assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

module ks_adder_32b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   output logic [32:0] out0
);
   logic [31:0]  p0;
   logic [31:0]  g0, g1, g2, g3, g4, g5;
   // Group propagate is only kept for bits that a later black cell still reads.
   logic [31:2]  p1;
   logic [31:4]  p2;
   logic [31:8]  p3;
   logic [31:16] p4;
   logic [32:0]  sum_d;
   logic [32:0]  sum_q;

   assign g0 = in0 & in1;
   assign p0 = in0 ^ in1;

   // Level 0, span 1
   assign g1[0] = g0[0];
   ks_grey_cell u_l0_grey (.g_hi_i(g0[1]), .p_hi_i(p0[1]), .g_lo_i(g0[0]), .g_o(g1[1]));
   for (genvar i = 2; i < 32; i++) begin : g_l0_black
      ks_black_cell u_cell (
         .g_hi_i(g0[i]), .p_hi_i(p0[i]), .g_lo_i(g0[i-1]), .p_lo_i(p0[i-1]),
         .g_o(g1[i]), .p_o(p1[i])
      );
   end

   // Level 1, span 2
   assign g2[1:0] = g1[1:0];
   for (genvar i = 2; i < 4; i++) begin : g_l1_grey
      ks_grey_cell u_cell (.g_hi_i(g1[i]), .p_hi_i(p1[i]), .g_lo_i(g1[i-2]), .g_o(g2[i]));
   end
   for (genvar i = 4; i < 32; i++) begin : g_l1_black
      ks_black_cell u_cell (
         .g_hi_i(g1[i]), .p_hi_i(p1[i]), .g_lo_i(g1[i-2]), .p_lo_i(p1[i-2]),
         .g_o(g2[i]), .p_o(p2[i])
      );
   end

   // Level 2, span 4
   assign g3[3:0] = g2[3:0];
   for (genvar i = 4; i < 8; i++) begin : g_l2_grey
      ks_grey_cell u_cell (.g_hi_i(g2[i]), .p_hi_i(p2[i]), .g_lo_i(g2[i-4]), .g_o(g3[i]));
   end
   for (genvar i = 8; i < 32; i++) begin : g_l2_black
      ks_black_cell u_cell (
         .g_hi_i(g2[i]), .p_hi_i(p2[i]), .g_lo_i(g2[i-4]), .p_lo_i(p2[i-4]),
         .g_o(g3[i]), .p_o(p3[i])
      );
   end

   // Level 3, span 8
   assign g4[7:0] = g3[7:0];
   for (genvar i = 8; i < 16; i++) begin : g_l3_grey
      ks_grey_cell u_cell (.g_hi_i(g3[i]), .p_hi_i(p3[i]), .g_lo_i(g3[i-8]), .g_o(g4[i]));
   end
   for (genvar i = 16; i < 32; i++) begin : g_l3_black
      ks_black_cell u_cell (
         .g_hi_i(g3[i]), .p_hi_i(p3[i]), .g_lo_i(g3[i-8]), .p_lo_i(p3[i-8]),
         .g_o(g4[i]), .p_o(p4[i])
      );
   end

   // Level 4, span 16: every remaining cell is terminal, so grey cells suffice
   assign g5[15:0] = g4[15:0];
   for (genvar i = 16; i < 32; i++) begin : g_l4_grey
      ks_grey_cell u_cell (.g_hi_i(g4[i]), .p_hi_i(p4[i]), .g_lo_i(g4[i-16]), .g_o(g5[i]));
   end

   assign sum_d[0]    = p0[0];
   assign sum_d[31:1] = p0[31:1] ^ g5[30:0];
   assign sum_d[32]   = g5[31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= 33'h0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign out0 = sum_q;

endmodule

// File: tb/tb_ks_adder_32b.sv
// Bench for ks_adder_32b: directed corner cases, reset behaviour and a random sweep,
// with expected sums queued at drive time and compared one cycle later.

module tb_ks_adder_32b;
   logic        clk;
   logic        rst_n;
   logic [31:0] in0;
   logic [31:0] in1;
   logic [32:0] out0;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];
   string       tag_q[$];

   ks_adder_32b dut (
      .clk  (clk),
      .rst_n(rst_n),
      .in0  (in0),
      .in1  (in1),
      .out0 (out0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare whatever is due this cycle, then drive the next operands.
   task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp, input bit push);
      @(negedge clk);
      if (exp_q.size() > 0) check(tag_q.pop_front(), out0, exp_q.pop_front());
      in0 = a;
      in1 = b;
      if (push) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;

      rst_n = 1'b0;
      in0   = 32'hFFFF_FFFF;
      in1   = 32'h0000_0001;

      #1 check("rst_async", out0, 33'h0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", out0, 33'h0);
      end
      rst_n = 1'b1;
      exp_q.push_back(33'h1_0000_0000);
      tag_q.push_back("rst_release");

      cycle("ripple_full", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 1'b1);
      cycle("ripple_31",   32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000, 1'b1);
      cycle("max",         32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b1);
      cycle("zero",        32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000, 1'b1);
      cycle("identity",    32'h1234_5678, 32'h0000_0000, 33'h0_1234_5678, 1'b1);
      cycle("all_prop",    32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF, 1'b1);
      cycle("pipe_0",      32'h0000_0001, 32'h0000_0002, 33'h0_0000_0003, 1'b1);
      cycle("pipe_1",      32'h0000_0003, 32'h0000_0004, 33'h0_0000_0007, 1'b1);
      cycle("pipe_2",      32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, 1'b1);
      cycle("drain", 32'h0, 32'h0, 33'h0, 1'b0);

      // Mid-stream reset: the registered sum is cleared and the queued result dropped.
      cycle("pre_rst", 32'hDEAD_BEEF, 32'h1111_1111, 33'h0_EFBE_D000, 1'b1);
      @(posedge clk);
      #2 check("pre_rst_val", out0, 33'h0_EFBE_D000);
      rst_n = 1'b0;
      #1 check("mid_rst_clr", out0, 33'h0);
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      check("mid_rst_hold", out0, 33'h0);
      rst_n = 1'b1;
      exp_q.push_back(33'h0_EFBE_D000);
      tag_q.push_back("post_rst");

      for (int n = 0; n < 20000; n++) begin
         a = $urandom();
         b = $urandom();
         if (n % 8 == 0) a = ~b;
         cycle("random", a, b, {1'b0, a} + {1'b0, b}, 1'b1);
      end
      cycle("drain", 32'h0, 32'h0, 33'h0, 1'b0);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
